// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter slice.
package mem_arb_pkg;

  localparam int MAX_WAIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ERR
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [63:0]       dm_wdata;
  logic [63:0]       dm_rdata;
  logic              dm_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ack;

  logic              stall;
  logic              err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall, err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall, err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Wait counter for a granted memory access; expired_o flags the last allowed BUSY cycle.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturates one short of MAX_WAIT: the next unacknowledged cycle is the one that reaches it.
  assign expired_o = (count_q == CW'(MAX_WAIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter for one shared memory port with ack timeout.
// Optional macro ARB_RR_EN: round-robin on contention instead of fixed data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       ifRdata_q, ifRdata_d;
  logic [63:0]       dmRdata_q, dmRdata_d;

  logic grantDm;
  logic wdClear;
  logic wdEnable;
  logic wdExpired;

  mem_arb_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wdClear),
    .enable_i  (wdEnable),
    .expired_o (wdExpired)
  );

`ifdef ARB_RR_EN
  owner_t lastOwner_q;

  // Reset value OWN_IF makes the first contended grant go to data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastOwner_q <= OWN_IF;
    end else if (state_q == DONE) begin
      lastOwner_q <= owner_q;
    end
  end

  always_comb begin
    grantDm = bus.dm_req;
    if (bus.dm_req && bus.if_req) begin
      grantDm = (lastOwner_q == OWN_IF);
    end
  end
`else
  always_comb begin
    grantDm = bus.dm_req;
  end
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ifRdata_d = ifRdata_q;
    dmRdata_d = dmRdata_q;
    wdClear   = 1'b0;
    wdEnable  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_d = BUSY;
          wdClear = 1'b1;
          if (grantDm) begin
            owner_d = OWN_DM;
            addr_d  = bus.dm_addr;
            we_d    = bus.dm_we;
            wdata_d = bus.dm_wdata;
          end else begin
            owner_d = OWN_IF;
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      BUSY: begin
        // An ack in the expiring cycle still completes the access.
        if (bus.mem_ack) begin
          state_d = DONE;
          if (owner_q == OWN_DM) begin
            dmRdata_d = bus.mem_rdata;
          end else begin
            ifRdata_d = bus.mem_rdata[31:0];
          end
        end else begin
          wdEnable = 1'b1;
          if (wdExpired) begin
            state_d = ERR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ifRdata_q <= '0;
      dmRdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ifRdata_q <= ifRdata_d;
      dmRdata_q <= dmRdata_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them without a clock.
  assign bus.mem_en    = (state_q == BUSY);
  assign bus.mem_we    = (state_q == BUSY) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ready  = (state_q == DONE) && (owner_q == OWN_IF);
  assign bus.dm_ready  = (state_q == DONE) && (owner_q == OWN_DM);
  assign bus.if_rdata  = ifRdata_q;
  assign bus.dm_rdata  = dmRdata_q;
  assign bus.err       = (state_q == ERR);
  assign bus.stall     = (bus.if_req && !bus.if_ready) || (bus.dm_req && !bus.dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W   (64),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: who was served last, and what each rdata register should hold.
  bit          lastWasDm;
  logic [31:0] expIfRdata;
  logic [63:0] expDmRdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit modelGrantDm(input bit wantIf, input bit wantDm);
    if (wantIf && wantDm) begin
`ifdef ARB_RR_EN
      return !lastWasDm;
`else
      return 1'b1;
`endif
    end
    return wantDm;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic applyReset();
    reset = 1'b0;
    #1;
    lastWasDm  = 1'b0;
    expIfRdata = '0;
    expDmRdata = '0;
    checkOutput("rst_mem_en", bus.mem_en, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_ready", {bus.if_ready, bus.dm_ready}, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_if_rdata", bus.if_rdata, 0);
    checkOutput("rst_dm_rdata", bus.dm_rdata, 0);
    @(negedge clk);
    bus.if_req  = 1'b0;
    bus.dm_req  = 1'b0;
    bus.mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge while the arbiter is idle; returns at the negedge of the following idle cycle.
  task automatic applyStimulus(input bit wantIf, input bit wantDm, input bit keepReqs,
                               input logic [63:0] ia, input logic [63:0] da,
                               input logic [63:0] dw, input bit dwe,
                               input logic [63:0] altDa, input int ackDelay,
                               input logic [63:0] rd);
    bit          gDm;
    logic [63:0] eAddr;
    bit          eWe;
    gDm   = modelGrantDm(wantIf, wantDm);
    eAddr = gDm ? da : ia;
    eWe   = gDm ? dwe : 1'b0;

    bus.if_req   = wantIf;
    bus.dm_req   = wantDm;
    bus.if_addr  = ia;
    bus.dm_addr  = da;
    bus.dm_wdata = dw;
    bus.dm_we    = dwe;
    #1;
    checkOutput("idle_stall", bus.stall, 1);
    checkOutput("idle_mem_en", bus.mem_en, 0);
    @(negedge clk);

    for (int k = 0; k <= ackDelay; k++) begin
      checkOutput("busy_mem_en", bus.mem_en, 1);
      checkOutput("busy_mem_addr", bus.mem_addr, eAddr);
      checkOutput("busy_mem_we", bus.mem_we, eWe);
      if (gDm) checkOutput("busy_mem_wdata", bus.mem_wdata, dw);
      checkOutput("busy_ready", {bus.if_ready, bus.dm_ready}, 0);
      checkOutput("busy_err", bus.err, 0);
      checkOutput("busy_stall", bus.stall, 1);
      if (k == ackDelay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
      end else begin
        bus.if_addr  = ~ia;
        bus.dm_addr  = altDa;
        bus.dm_wdata = ~dw;
        bus.dm_we    = ~dwe;
      end
      @(negedge clk);
    end

    bus.mem_ack   = 1'b0;
    bus.mem_rdata = rand64();
    if (gDm) expDmRdata = rd;
    else     expIfRdata = rd[31:0];
    checkOutput("done_if_ready", bus.if_ready, {63'd0, !gDm});
    checkOutput("done_dm_ready", bus.dm_ready, {63'd0, gDm});
    checkOutput("done_if_rdata", bus.if_rdata, {32'd0, expIfRdata});
    checkOutput("done_dm_rdata", bus.dm_rdata, expDmRdata);
    checkOutput("done_mem_en", bus.mem_en, 0);
    checkOutput("done_err", bus.err, 0);
    lastWasDm = gDm;
    if (!keepReqs) begin
      if (gDm) bus.dm_req = 1'b0;
      else     bus.if_req = 1'b0;
    end
    @(negedge clk);

    checkOutput("idle_ready", {bus.if_ready, bus.dm_ready}, 0);
    checkOutput("idle_mem_en_after", bus.mem_en, 0);
    if (!keepReqs) begin
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] r3;
    logic [63:0] r4;
    int          pat;

    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    @(negedge clk);
    applyReset();
    checkOutput("rst_stall", bus.stall, 0);

    // Single fetch with minimum latency.
    applyStimulus(1, 0, 0, 64'h40, 64'h0, 64'h0, 0, 64'h0, 0, 64'h00000000_91000421);
    checkOutput("fetch_if_rdata", bus.if_rdata, 64'h91000421);

    // Data write acked in the third BUSY cycle while dm_addr moves 0x8 -> 0x10.
    applyStimulus(0, 1, 0, 64'h0, 64'h8, 64'hDEAD, 1, 64'h10, 2, 64'h1234_5678_9ABC_DEF0);

    // Ack outside BUSY must be ignored.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checkOutput("stray_ack_mem_en", bus.mem_en, 0);
    checkOutput("stray_ack_ready", {bus.if_ready, bus.dm_ready}, 0);
    checkOutput("stray_ack_if_rdata", bus.if_rdata, {32'd0, expIfRdata});
    checkOutput("stray_ack_dm_rdata", bus.dm_rdata, expDmRdata);
    @(negedge clk);
    checkOutput("stray_ack_idle", bus.mem_en, 0);

    // Contention from reset: four transactions with both requests held.
    applyReset();
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1, 1, 1, 64'h100 + 64'(t), 64'h200 + 64'(t), rand64(), 0,
                    64'h300, $urandom_range(0, MAXW - 1), rand64());
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);

    // Ack in the last allowed cycle completes without error.
    applyStimulus(0, 1, 0, 64'h0, 64'h55, 64'h66, 0, 64'h77, MAXW - 1, 64'hCAFE);

    // Timeout: no ack for MAX_WAIT BUSY cycles.
    bus.dm_req  = 1'b1;
    bus.dm_addr = 64'h88;
    bus.dm_we   = 1'b1;
    @(negedge clk);
    for (int k = 0; k < MAXW; k++) begin
      checkOutput("to_busy_mem_en", bus.mem_en, 1);
      checkOutput("to_busy_err", bus.err, 0);
      @(negedge clk);
    end
    checkOutput("to_err", bus.err, 1);
    checkOutput("to_mem_en", bus.mem_en, 0);
    checkOutput("to_mem_we", bus.mem_we, 0);
    checkOutput("to_ready", {bus.if_ready, bus.dm_ready}, 0);
    bus.dm_req  = 1'b0;
    bus.if_req  = 1'b1;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checkOutput("to_err_sticky", bus.err, 1);
    checkOutput("to_mem_en_held", bus.mem_en, 0);
    checkOutput("to_ready_held", {bus.if_ready, bus.dm_ready}, 0);
    bus.if_req = 1'b0;
    applyReset();
    checkOutput("to_err_cleared", bus.err, 0);

    // Reset mid-BUSY drops the port without a clock edge.
    bus.dm_req   = 1'b1;
    bus.dm_addr  = 64'hABC0;
    bus.dm_wdata = 64'h1111;
    bus.dm_we    = 1'b1;
    @(negedge clk);
    checkOutput("mid_busy_mem_en", bus.mem_en, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_mem_en", bus.mem_en, 0);
    checkOutput("mid_rst_mem_we", bus.mem_we, 0);
    checkOutput("mid_rst_mem_addr", bus.mem_addr, 0);
    bus.dm_req = 1'b0;
    applyReset();
    applyStimulus(1, 0, 0, 64'h4000, 64'h0, 64'h0, 0, 64'h0, 1, 64'h0BAD_F00D_0000_0007);

    // Randomized mix of fetch-only, data-only and contended requests.
    for (int t = 0; t < 24; t++) begin
      pat = $urandom_range(0, 2);
      r1  = rand64();
      r2  = rand64();
      r3  = rand64();
      r4  = rand64();
      applyStimulus(pat != 1, pat != 0, 0, r1, r2, r3, $urandom_range(0, 1) == 1,
                    r4, $urandom_range(0, MAXW - 1), rand64());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
